// File: rtl/div_operand_capture.sv
// div_operand_capture: synchronizes and debounces the active-low numerator
// switches and denominator keys. Each new settled operand pair is offered to
// a divider through a valid/ready handshake.
// Optional feature macro: DIV_ZERO_BLOCK_EN. When it is defined, a pair with
// a zero denominator is withheld and div_zero is flagged.
module div_operand_capture #(
    parameter int DEB_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic [3:0] key,
    output logic [3:0] numerator,
    output logic [3:0] denominator,
    output logic       op_valid,
    input  logic       op_ready,
    output logic       div_zero
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [3:0]       sw_meta_q, sw_sync_q, sw_prev_q, sw_stable_q, sw_stable_d;
    logic [3:0]       key_meta_q, key_sync_q, key_prev_q, key_stable_q, key_stable_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d, key_cnt_q, key_cnt_d;
    logic [3:0]       num_q, num_d, den_q, den_d;
    logic [3:0]       last_num_q, last_num_d, last_den_q, last_den_d;
    logic [3:0]       cand_num, cand_den;
    logic             cand_ok;
    state_t           state_q, state_d;

    // Debounce: restart on any change or when already settled; load on reaching the limit
    always_comb begin
        sw_cnt_d     = '0;
        sw_stable_d  = sw_stable_q;
        key_cnt_d    = '0;
        key_stable_d = key_stable_q;
        if (sw_sync_q != sw_stable_q && sw_sync_q == sw_prev_q && sw_cnt_q != CNT_MAX) begin
            sw_cnt_d = sw_cnt_q + 1'b1;
            if (sw_cnt_d == CNT_MAX) sw_stable_d = sw_sync_q;
        end
        if (key_sync_q != key_stable_q && key_sync_q == key_prev_q && key_cnt_q != CNT_MAX) begin
            key_cnt_d = key_cnt_q + 1'b1;
            if (key_cnt_d == CNT_MAX) key_stable_d = key_sync_q;
        end
    end

    // Synchronizers, change-detect history, debounce counters and stable values
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q    <= 4'hF;
            sw_sync_q    <= 4'hF;
            sw_prev_q    <= 4'hF;
            sw_stable_q  <= 4'hF;
            sw_cnt_q     <= '0;
            key_meta_q   <= 4'hF;
            key_sync_q   <= 4'hF;
            key_prev_q   <= 4'hF;
            key_stable_q <= 4'hF;
            key_cnt_q    <= '0;
        end else begin
            sw_meta_q    <= sw;
            sw_sync_q    <= sw_meta_q;
            sw_prev_q    <= sw_sync_q;
            sw_stable_q  <= sw_stable_d;
            sw_cnt_q     <= sw_cnt_d;
            key_meta_q   <= key;
            key_sync_q   <= key_meta_q;
            key_prev_q   <= key_sync_q;
            key_stable_q <= key_stable_d;
            key_cnt_q    <= key_cnt_d;
        end
    end

    assign cand_num = ~sw_stable_q;
    assign cand_den = ~key_stable_q;

`ifdef DIV_ZERO_BLOCK_EN
    logic div_zero_q, div_zero_d;

    assign cand_ok = (cand_den != 4'h0);

    // Zero flag tracks the stable denominator on the same edge it settles
    always_comb begin
        div_zero_d = (key_stable_d == 4'hF);
    end

    // Registered divide-by-zero flag
    always_ff @(posedge clk) begin
        if (rst) div_zero_q <= 1'b0;
        else     div_zero_q <= div_zero_d;
    end

    assign div_zero = div_zero_q;
`else
    assign cand_ok  = 1'b1;
    assign div_zero = 1'b0;
`endif

    // Handshake FSM: offer a new pair, hold it steady until the divider takes it
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        den_d      = den_q;
        last_num_d = last_num_q;
        last_den_d = last_den_q;
        case (state_q)
            IDLE: begin
                if (cand_ok && {cand_num, cand_den} != {last_num_q, last_den_q}) begin
                    state_d = SEND;
                    num_d   = cand_num;
                    den_d   = cand_den;
                end
            end
            SEND: begin
                if (op_ready) begin
                    state_d    = IDLE;
                    last_num_d = num_q;
                    last_den_d = den_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, presented operands and last accepted pair
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            num_q      <= 4'h0;
            den_q      <= 4'h0;
            last_num_q <= 4'h0;
            last_den_q <= 4'h0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            den_q      <= den_d;
            last_num_q <= last_num_d;
            last_den_q <= last_den_d;
        end
    end

    assign numerator   = num_q;
    assign denominator = den_q;
    assign op_valid    = (state_q == SEND);

endmodule

// File: doc/div_operand_capture.md
DIV_OPERAND_CAPTURE -- requirements
Module: div_operand_capture

Interface
REQ-001 The block SHALL have one parameter: DEB_CYCLES, default 240000, the number of stable clock cycles needed to accept a new switch/key value (20 ms at 12 MHz); legal range is 2 or more.
REQ-002 The block SHALL have input port clk, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have input port rst, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have input port sw, 4 bits: raw, asynchronous, active-low numerator switches.
REQ-005 The block SHALL have input port key, 4 bits: raw, asynchronous, active-low denominator keys.
REQ-006 The block SHALL have output port numerator, 4 bits: debounced, active-high numerator presented to the divider.
REQ-007 The block SHALL have output port denominator, 4 bits: debounced, active-high denominator presented to the divider.
REQ-008 The block SHALL have output port op_valid, 1 bit: the operand pair is valid.
REQ-009 The block SHALL have input port op_ready, 1 bit: the divider accepts the pair.
REQ-010 The block SHALL have output port div_zero, 1 bit: the debounced denominator is zero (see Configuration).

Function
REQ-011 Each bit of sw and key SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The block SHALL keep a separate debounce counter for sw and for key.
REQ-013 A debounce counter SHALL clear whenever its synchronized bus equals its stable register, or whenever the synchronized bus changes value.
REQ-014 A debounce counter SHALL otherwise increment.
REQ-015 The stable register SHALL load the synchronized bus on the edge where the counter reaches DEB_CYCLES-1.
REQ-016 The counter width SHALL be $clog2(DEB_CYCLES); the counter SHALL never wrap.
REQ-017 The candidate pair SHALL be {~stable_sw, ~stable_key}.
REQ-018 The handshake FSM SHALL have two states, IDLE and SEND.
REQ-019 IDLE -> SEND SHALL occur when the candidate pair differs from the last accepted pair; numerator and denominator load the candidate on the same edge.
REQ-020 In SEND, op_valid SHALL be 1; numerator and denominator SHALL hold constant even if the candidate pair changes.
REQ-021 SEND -> IDLE SHALL occur on the edge where op_valid and op_ready are both 1; the last accepted pair updates to the presented pair.
REQ-022 If the candidate still differs from the last accepted pair after a handshake, SEND SHALL re-enter one cycle later (IDLE lasts 1 cycle); there is no queue and only the newest candidate is sent.
REQ-023 op_ready while in IDLE SHALL be ignored.
REQ-024 End-to-end latency from a clean input change to op_valid=1 SHALL be exactly DEB_CYCLES+3 clock edges: 2 synchronizer edges, DEB_CYCLES debounce edges, 1 FSM edge.
REQ-025 When sw and key change simultaneously, each SHALL debounce independently; a pair whose halves settle on different cycles MAY produce two transactions.

Reset
REQ-026 While rst=1, the synchronizers and stable registers SHALL be set to 4'b1111 (released).
REQ-027 While rst=1, the counters SHALL be 0, the last accepted pair SHALL be 0/0, and the FSM SHALL be IDLE.
REQ-028 While rst=1, numerator, denominator, op_valid and div_zero SHALL all be 0.
REQ-029 A rst asserted during SEND SHALL drop op_valid on that same edge and discard the pending pair.
REQ-030 No transaction SHALL occur after reset until an input changes.

Configuration
REQ-031 Divide-by-zero blocking SHALL be compiled in when DIV_ZERO_BLOCK_EN is defined.
REQ-032 With DIV_ZERO_BLOCK_EN defined, a candidate pair with denominator 0 SHALL NOT cause IDLE -> SEND.
REQ-033 With DIV_ZERO_BLOCK_EN defined, div_zero SHALL be registered and equal 1 while ~stable_key==0, and the last accepted pair SHALL be unchanged.
REQ-034 Without DIV_ZERO_BLOCK_EN, every pair SHALL be sent, including denominator 0, and div_zero SHALL be constant 0.

Verification (DEB_CYCLES=4, op_ready=1 unless stated)
REQ-035 Reset: rst=1 for 3 cycles with sw=key=4'b0000 -> all outputs 0; after release, op_valid rises 7 edges later with numerator=4'hF and denominator=4'hF.
REQ-036 Latency: sw=~4'b0110 and key=~4'b0010 applied together -> op_valid=1 on edge 7, numerator=6, denominator=2; op_valid=0 on edge 8.
REQ-037 Bounce: toggle sw[0] every 2 cycles for 20 cycles, then hold -> no op_valid during toggling; exactly one transaction 7 edges after the final change.
REQ-038 Backpressure: op_ready=0 and pair 6/2 pending; change sw to ~4'b1001 -> numerator stays 6 until op_ready=1 handshake; numerator=9 with op_valid=1 two edges later.
REQ-039 Zero: key=4'b1111 and sw=~4'b0101 -> with DIV_ZERO_BLOCK_EN, no op_valid and div_zero=1; without it, op_valid=1 with numerator=5, denominator=0, div_zero=0.
REQ-040 Mid-reset: rst=1 for 1 cycle while op_valid=1 -> op_valid=0 on that edge and no handshake is recorded.
